// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: source handshakes, register-file write port and hazard probe
interface regfile_write_arbiter_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                    mem_valid;
  logic [ADDR_W-1:0]       mem_rd;
  logic [DATA_W-1:0]       mem_data;
  logic                    mem_ready;
  logic                    alu_valid;
  logic [ADDR_W-1:0]       alu_rd;
  logic [DATA_W-1:0]       alu_data;
  logic                    alu_ready;
  logic                    register_write_valid;
  logic [ADDR_W-1:0]       write_reg;
  logic [DATA_W-1:0]       reg_write_data;
  logic [ADDR_W-1:0]       query_reg;
  logic                    pending_hit;
  logic [$clog2(DEPTH):0]  count;
  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, query_reg,
    input  mem_ready, alu_ready, register_write_valid, write_reg, reg_write_data,
           pending_hit, count
  );
  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data, query_reg,
    output mem_ready, alu_ready, register_write_valid, write_reg, reg_write_data,
           pending_hit, count
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: merges load and ALU results into one in-order register-file write stream
module regfile_write_arbiter #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input logic                   clk,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [ADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [AW-1:0]     r_head;
  logic [AW-1:0]     r_tail;
  logic [CW-1:0]     r_count;
  logic              r_wv;
  logic [ADDR_W-1:0] r_wreg;
  logic [DATA_W-1:0] r_wdata;

  logic [CW-1:0]     w_free;
  logic              w_mem_ready;
  logic              w_alu_ready;
  logic              w_mem_push;
  logic              w_alu_push;
  logic              w_drain;
  logic [AW-1:0]     w_alu_slot;
  logic              w_hit;

  assign w_free      = CW'(DEPTH) - r_count;
  assign w_mem_ready = w_free >= CW'(1);
  assign w_mem_push  = bus.mem_valid && w_mem_ready && (bus.mem_rd != '0);
  // the ALU only needs a second slot when the load actually occupies one
  assign w_alu_ready = w_free >= (CW'(1) + CW'(w_mem_push));
  assign w_alu_push  = bus.alu_valid && w_alu_ready && (bus.alu_rd != '0);
  assign w_drain     = r_count != '0;
  assign w_alu_slot  = r_tail + AW'(w_mem_push);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_wv    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else begin
      r_wv <= w_drain;
      if (w_drain) begin
        r_wreg  <= r_rd[r_head];
        r_wdata <= r_data[r_head];
        r_head  <= r_head + AW'(1);
      end
      if (w_mem_push) begin
        r_rd[r_tail]   <= bus.mem_rd;
        r_data[r_tail] <= bus.mem_data;
      end
      if (w_alu_push) begin
        r_rd[w_alu_slot]   <= bus.alu_rd;
        r_data[w_alu_slot] <= bus.alu_data;
      end
      r_tail  <= r_tail + AW'(w_mem_push) + AW'(w_alu_push);
      r_count <= r_count + CW'(w_mem_push) + CW'(w_alu_push) - CW'(w_drain);
    end
  end

  always_comb begin
    w_hit = r_wv && (r_wreg == bus.query_reg);
    for (int i = 0; i < DEPTH; i++)
      if ((CW'(i) < r_count) && (r_rd[r_head + AW'(i)] == bus.query_reg)) w_hit = 1'b1;
  end

  assign bus.mem_ready            = w_mem_ready;
  assign bus.alu_ready            = w_alu_ready;
  assign bus.register_write_valid = r_wv;
  assign bus.write_reg            = r_wreg;
  assign bus.reg_write_data       = r_wdata;
  assign bus.pending_hit          = w_hit && (bus.query_reg != '0);
  assign bus.count                = r_count;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: random two-source traffic checked against a queue-based model
module tb_regfile_write_arbiter;
  localparam int DEPTH = 4;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  ent_t q[$];
  logic m_wv = 1'b0;
  logic [4:0] m_wreg = '0;
  logic [31:0] m_wdata = '0;

  regfile_write_arbiter_if #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) bus ();
  regfile_write_arbiter #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] pick_rd();
    return ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
  endfunction

  initial begin
    bus.mem_valid = 1'b1; bus.alu_valid = 1'b1;
    bus.mem_rd = 5'd3; bus.alu_rd = 5'd4;
    bus.mem_data = 32'h1; bus.alu_data = 32'h2;
    bus.query_reg = 5'd3;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (c < 2) begin
        reset = 1'b0;
        bus.mem_valid = 1'b1; bus.alu_valid = 1'b1;
      end else begin
        logic burst;
        burst = ((c / 40) % 2) == 0;
        reset = ($urandom_range(0, 99) == 0) ? 1'b0 : 1'b1;
        bus.mem_valid = burst ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        bus.alu_valid = burst ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 2) == 0);
        bus.mem_rd = pick_rd();
        bus.alu_rd = pick_rd();
        bus.mem_data = $urandom;
        bus.alu_data = $urandom;
        if (q.size() > 0 && $urandom_range(0, 1) == 1)
          bus.query_reg = q[$urandom_range(0, q.size() - 1)].rd;
        else
          bus.query_reg = 5'($urandom_range(0, 31));
      end
      #1;
      begin
        int free;
        logic e_mr, e_ar, e_hit, mem_take, alu_take;
        free = DEPTH - q.size();
        e_mr = free >= 1;
        mem_take = bus.mem_valid && e_mr && bus.mem_rd != 0;
        e_ar = free >= 1 + (mem_take ? 1 : 0);
        alu_take = bus.alu_valid && e_ar && bus.alu_rd != 0;
        e_hit = 1'b0;
        if (bus.query_reg != 0) begin
          foreach (q[i]) if (q[i].rd == bus.query_reg) e_hit = 1'b1;
          if (m_wv && m_wreg == bus.query_reg) e_hit = 1'b1;
        end
        if (c > 0) begin
          chk("count", 32'(bus.count), 32'(q.size()));
          chk("mem_ready", 32'(bus.mem_ready), 32'(e_mr));
          chk("alu_ready", 32'(bus.alu_ready), 32'(e_ar));
          chk("pending_hit", 32'(bus.pending_hit), 32'(e_hit));
          chk("wr_valid", 32'(bus.register_write_valid), 32'(m_wv));
          chk("write_reg", 32'(bus.write_reg), 32'(m_wreg));
          chk("wr_data", bus.reg_write_data, m_wdata);
        end
        if (!reset) begin
          q.delete();
          m_wv = 1'b0; m_wreg = '0; m_wdata = '0;
        end else begin
          if (q.size() > 0) begin
            ent_t h;
            h = q.pop_front();
            m_wv = 1'b1; m_wreg = h.rd; m_wdata = h.d;
          end else begin
            m_wv = 1'b0;
          end
          if (mem_take) q.push_back('{rd: bus.mem_rd, d: bus.mem_data});
          if (alu_take) q.push_back('{rd: bus.alu_rd, d: bus.alu_data});
        end
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
